imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream and writes 32-bit words into the instruction ROM array, starting at word 0.
- Gates the core: holds `iready` low and `cpu_rst_n` low while loading; releases both once the image is complete.
- Sits between a byte source (UART receiver or testbench) and the imem write port plus datapath reset.

Parameters:
- ROW, 256, instruction memory depth in words.
- ADDR_W, 8, word-address width; must equal clog2(ROW).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  byte-stream valid.
- rx_data  in  8  byte-stream data.
- rx_ready  out  1  loader can accept a byte.
- boot_req  in  1  restart loading; honoured only in RUN or ERR.
- imem_we  out  1  one-cycle imem write strobe.
- imem_waddr  out  ADDR_W  word index (byte address = waddr<<2).
- imem_wdata  out  32  instruction word.
- iready  out  1  instruction memory valid to the core.
- cpu_rst_n  out  1  active-low reset to the datapath.
- load_err  out  1  sticky error flag, cleared on leaving ERR.

Behaviour:
- Byte transfer: a byte is accepted on a rising edge where rx_valid && rx_ready. rx_data is sampled only on acceptance.
- rx_ready is combinational from state: 1 in LEN0, LEN1, DATA and CHK; 0 in RUN and ERR.
- Frame format:
  - LEN_LO, then LEN_HI: 16-bit word count N.
  - N words, 4 bytes each, little-endian: first byte goes to wdata[7:0].
  - CHK byte, only when the optional feature is enabled.
- States: LEN0, LEN1, DATA, CHK, RUN, ERR.
- Reset values:
  - state = LEN0; byte counter = 0; word counter = 0.
  - imem_we = 0; imem_waddr = 0; imem_wdata = 0.
  - iready = 0; cpu_rst_n = 0; load_err = 0.
  - rx_ready = 1, because reset state is LEN0.
- LEN0: on acceptance, latch N[7:0]; go to LEN1.
- LEN1: on acceptance, latch N[15:8] and evaluate the assembled N:
  - N > ROW → ERR.
  - N == 0 → CHK if enabled, else RUN.
  - otherwise → DATA, with byte counter = 0 and word counter = 0.
- DATA:
  - Each accepted byte shifts into an assembly register; the byte counter increments modulo 4.
  - On the 4th byte, the next edge registers imem_we = 1 for exactly one cycle, with imem_wdata = {b3,b2,b1,b0} and imem_waddr = word counter[ADDR_W-1:0]; the word counter then increments.
  - Acceptance of the 4th byte of word N-1 moves to CHK if enabled, else RUN, on the same edge that registers the final imem_we.
- RUN:
  - iready and cpu_rst_n are registered from (state == RUN), so both rise one cycle after entering RUN.
  - The final imem write therefore always lands before the core leaves reset.
- ERR: load_err = 1 from the edge entering ERR; iready = 0, cpu_rst_n = 0.
- boot_req:
  - In RUN or ERR, boot_req = 1 → LEN0 on the next edge; iready, cpu_rst_n and load_err drop one cycle later; counters cleared.
  - In any other state boot_req is ignored.
- rx_valid with rx_ready = 0 (RUN/ERR): the byte is dropped; no state change.
- Gaps: rx_valid may deassert between any bytes; there is no timeout, and partial words are held indefinitely.
- Reset mid-load: everything returns to reset values. Words already written remain in imem (no clear), and the core stays held.
- Word counter is 16 bits. Because N ≤ ROW, imem_waddr never wraps.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - A running XOR of every accepted byte, from LEN_LO through the last data byte, is kept and cleared on entering LEN0.
  - CHK state accepts one byte: equal to the running XOR → RUN; different → ERR.
- Undefined:
  - CHK state and XOR logic are absent; DATA (or LEN1 with N = 0) goes directly to RUN.

Test Plan:
- Reset, then stream 01 00 13 00 50 00 (N=1, word 0x00500013) → one imem_we pulse with waddr=0, wdata=0x00500013; iready=1 and cpu_rst_n=1 one cycle after RUN; rx_ready=0.
- N=3 with rx_valid toggling every other cycle → three imem_we pulses at waddr 0,1,2 with the correct little-endian words; no extra strobes.
- Length 01 01 (N=257 > 256) → ERR after the LEN_HI byte, load_err=1, iready=0, no imem_we.
- In RUN, pulse boot_req, then send N=0 → LEN0, with iready and cpu_rst_n low for at least one cycle, then RUN again with no imem_we.
- Assert rst_n=0 after 2 of 4 bytes of word 0 → all outputs at reset values and state LEN0; a subsequent full frame loads correctly.
- With IMEM_BOOT_CHECKSUM_EN, frame 01 00 13 00 50 00 + CHK=0x42 (= XOR of all six bytes) → RUN. The same frame with CHK=0x43 → ERR and load_err=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//   Writer side of the instruction memory. A program arrives as a byte stream:
//   a 16-bit little-endian word count N, then N little-endian 32-bit words. Each
//   completed word is written to the instruction ROM starting at word 0. The
//   core is held off (iready = 0, cpu_rst_n = 0) until the image is complete.
//
//   Optional feature (macro IMEM_BOOT_CHECKSUM_EN): a trailing CHK byte must
//   equal the XOR of every byte from LEN_LO through the last data byte.
//   Otherwise the loader enters ERR. With the macro undefined, the CHK state
//   and the XOR logic do not exist.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_valid, rx_data   byte-stream input (accepted when rx_valid && rx_ready)
//   rx_ready            loader can accept a byte (LEN0/LEN1/DATA/CHK)
//   boot_req            restart loading (honoured in RUN or ERR only)
//   imem_we             one-cycle imem write strobe
//   imem_waddr          word index of the write
//   imem_wdata          instruction word
//   iready              instruction memory valid to the core
//   cpu_rst_n           active-low reset to the datapath
//   load_err            sticky error flag, cleared one cycle after leaving ERR
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int ROW    = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              boot_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              iready,
  output logic              cpu_rst_n,
  output logic              load_err
);

  typedef enum logic [2:0] {
    ST_LEN0 = 3'd0,
    ST_LEN1 = 3'd1,
    ST_DATA = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
`ifdef IMEM_BOOT_CHECKSUM_EN
    ,
    ST_CHK  = 3'd5
`endif
  } state_e;

  localparam logic [15:0] ROW_LEN = 16'(ROW);

  // State the loader moves to once the last word (or an empty image) is in.
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam state_e LOAD_DONE = ST_CHK;
`else
  localparam state_e LOAD_DONE = ST_RUN;
`endif

`ifdef IMEM_BOOT_CHECKSUM_EN
  // Running checksum step: fold one accepted byte into the accumulator.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  state_e       state_r;
  state_e       state_nxt_s;
  logic [1:0]   byte_cnt_r;
  logic [15:0]  word_cnt_r;
  logic [15:0]  len_r;
  logic [23:0]  asm_r;       // {b2, b1, b0} of the word being assembled
  logic         accept_s;
  logic         last_byte_s;
  logic [15:0]  len_full_s;
  logic [15:0]  word_inc_s;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]   xor_r;
`endif

  assign accept_s    = rx_valid && rx_ready;
  assign last_byte_s = (byte_cnt_r == 2'd3);
  assign len_full_s  = {rx_data, len_r[7:0]};
  assign word_inc_s  = word_cnt_r + 16'd1;

  // rx_ready decoded from state: open while the frame is still being received.
  always_comb begin
    rx_ready = 1'b0;
    case (state_r)
      ST_LEN0, ST_LEN1, ST_DATA: rx_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CHK:                    rx_ready = 1'b1;
`endif
      default:                   rx_ready = 1'b0;
    endcase
  end

  // Next-state logic for the frame parser.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LEN0: begin
        if (accept_s) state_nxt_s = ST_LEN1;
        else          state_nxt_s = state_r;
      end
      ST_LEN1: begin
        if (accept_s) begin
          if (len_full_s > ROW_LEN)     state_nxt_s = ST_ERR;
          else if (len_full_s == 16'd0) state_nxt_s = LOAD_DONE;
          else                          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DATA: begin
        // The 4th byte of word N-1 finishes the image.
        if (accept_s && last_byte_s && (word_inc_s == len_r)) state_nxt_s = LOAD_DONE;
        else                                                  state_nxt_s = state_r;
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CHK: begin
        if (accept_s) begin
          if (rx_data == xor_r) state_nxt_s = ST_RUN;
          else                  state_nxt_s = ST_ERR;
        end else begin
          state_nxt_s = state_r;
        end
      end
`endif
      ST_RUN, ST_ERR: begin
        if (boot_req) state_nxt_s = ST_LEN0;
        else          state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_LEN0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_LEN0;
    else        state_r <= state_nxt_s;
  end

  // Core gating flags: both lag the RUN/ERR state by one cycle, so the final
  // imem write always lands before the core leaves reset. load_err is set on
  // the edge entering ERR and held through the cycle that leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iready    <= 1'b0;
      cpu_rst_n <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      iready    <= (state_r == ST_RUN);
      cpu_rst_n <= (state_r == ST_RUN);
      load_err  <= (state_nxt_s == ST_ERR) || (state_r == ST_ERR);
    end
  end

  // Length capture, word assembly, counters and the imem write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_r <= 2'd0;
      word_cnt_r <= 16'd0;
      len_r      <= 16'd0;
      asm_r      <= 24'd0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      case (state_r)
        ST_LEN0: begin
          if (accept_s) len_r[7:0] <= rx_data;
        end
        ST_LEN1: begin
          if (accept_s) begin
            len_r[15:8] <= rx_data;
            byte_cnt_r  <= 2'd0;
            word_cnt_r  <= 16'd0;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (last_byte_s) begin
              imem_we    <= 1'b1;
              imem_wdata <= {rx_data, asm_r};
              imem_waddr <= word_cnt_r[ADDR_W-1:0];
              word_cnt_r <= word_inc_s;
            end else begin
              // Shift in from the top so b0 ends up in the low byte.
              asm_r <= {rx_data, asm_r[23:8]};
            end
          end
        end
        ST_RUN, ST_ERR: begin
          if (boot_req) begin
            byte_cnt_r <= 2'd0;
            word_cnt_r <= 16'd0;
            len_r      <= 16'd0;
            asm_r      <= 24'd0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_BOOT_CHECKSUM_EN
  // Running XOR over the length and data bytes; cleared on re-entering LEN0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_r <= 8'd0;
    end else if ((state_r == ST_RUN || state_r == ST_ERR) && boot_req) begin
      xor_r <= 8'd0;
    end else if (accept_s && (state_r == ST_LEN0 || state_r == ST_LEN1 || state_r == ST_DATA)) begin
      xor_r <= xor_fold(xor_r, rx_data);
    end
  end
`endif

endmodule
